gpio_serial_loader: RTL and testbench
=====================================

Name: gpio_serial_loader

Overview:
Hardware sequencer that shifts the per-GPIO configuration words into the two user-area GPIO control chains. It replaces slow host-driven bit-banging through the housekeeping SPI. It generates serial clock, two serial data streams (chain 1 from the GPIO 0 end, chain 2 from the GPIO 37 end), the chain load strobe and the chain reset. It also arbitrates the chain pins between its own engine and the existing register-driven bit-bang path.

Parameters:
N_IO, 19, GPIO control blocks per chain
CFG_W, 13, configuration bits per GPIO block
CLK_DIV, 4, wb_clk_i cycles per serial-clock half period (>=1)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous reset, active high
start  in  1  one-cycle request to shift and load both chains
cfg_addr  out  $clog2(N_IO)  index of the config word being fetched
cfg1_word  in  CFG_W  chain-1 config word for cfg_addr (combinational source)
cfg2_word  in  CFG_W  chain-2 config word for cfg_addr
bb_en  in  1  bit-bang mode: pins follow bb_* inputs
bb_resetn  in  1  bit-bang chain reset
bb_load  in  1  bit-bang load
bb_clock  in  1  bit-bang serial clock
bb_data1  in  1  bit-bang data, chain 1
bb_data2  in  1  bit-bang data, chain 2
serial_resetn  out  1  chain reset, active low
serial_load  out  1  chain load strobe
serial_clock  out  1  chain shift clock
serial_data1  out  1  chain-1 serial data
serial_data2  out  1  chain-2 serial data
busy  out  1  engine transfer in progress
done  out  1  one-cycle pulse at transfer completion

Behaviour:
- Reset: state IDLE; cfg_addr=N_IO-1; busy=0, done=0. Engine-side pin values: resetn=0, load=0, clock=0, data1=0, data2=0. After reset release, engine resetn=1.
- Pin mux, registered: outputs take the bb_* values when bb_en=1, otherwise the engine values. The mux adds one cycle of latency.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE: start=1 and bb_en=0 moves to FETCH on the next cycle and sets busy=1. start is ignored when bb_en=1 or when the engine is not in IDLE.
- FETCH (1 cycle): cfg_addr is stable. At the end of the cycle, cfg1_word and cfg2_word are captured into shift registers and bit counter = CFG_W-1.
- SHIFT_LO (CLK_DIV cycles): clock=0; data1/data2 = captured bit[counter]. Words are shifted MSB first.
- SHIFT_HI (CLK_DIV cycles): clock=1; data is held.
- SHIFT_HI exit:
  - counter>0: decrement counter, go to SHIFT_LO.
  - counter=0 and cfg_addr>0: decrement cfg_addr, go to FETCH.
  - counter=0 and cfg_addr=0: go to LATCH.
- Word order: cfg_addr runs N_IO-1 down to 0, so the farthest block's word is shifted first.
- LATCH (CLK_DIV cycles): load=1, clock=0. Then DONE.
- DONE (1 cycle): done=1, load=0; busy drops to 0 on the next cycle; cfg_addr returns to N_IO-1; state returns to IDLE.
- Latency: the cycle after start is sampled is FETCH #1. done is asserted at cycle N_IO*(1+2*CFG_W*CLK_DIV)+CLK_DIV+1 after that. Default parameters give 2000.
- bb_en rising while busy: abort on the next cycle to IDLE. Engine values return to reset values except resetn=1; busy=0; no done pulse. A later start restarts from cfg_addr=N_IO-1.
- Per chain, exactly N_IO*CFG_W rising serial_clock edges and one load pulse per completed transfer.
- Data changes only in the first cycle of SHIFT_LO, never while clock=1.
- wb_rst_i mid-transfer: immediate return to reset state; serial_resetn=0 for that cycle and the cycle after it (one-cycle output register).

Test Plan:
- N_IO=2, CFG_W=4, CLK_DIV=1. Words cfg_addr1: ch1=0xA, ch2=0x5; cfg_addr0: ch1=0x3, ch2=0xC. start pulse -> data1 sampled on clock rises = 1,0,1,0,0,0,1,1; data2 = 0,1,0,1,1,1,0,0. load high 1 cycle; done pulse 20 cycles after FETCH #1.
- Defaults with a model shift chain (reset 0) and words 0x1809 for every block -> exactly 247 clock rises; after load every model register = 0x1809; done at 2000 cycles.
- start while busy, and start while bb_en=1 -> ignored; edge count and done timing unchanged; no transfer when bb_en=1.
- bb_en=1 with bb_clock toggled and bb_data1=1 -> serial_clock/serial_data1 mirror the inputs one cycle later; serial_resetn follows bb_resetn.
- bb_en asserted mid-shift (bit 5 of word 7) -> busy=0 and engine clock/load 0 next cycle; no done. After bb_en deasserts, a new start produces a full 247-edge transfer.
- wb_rst_i pulsed during LATCH -> load=0, resetn=0 for 2 cycles, busy=0, no done; cfg_addr=N_IO-1.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// Shifts per-GPIO configuration words into the two user-area GPIO control chains
// and muxes the chain pins between this engine and the register bit-bang path.
module gpio_serial_loader #(
   parameter int N_IO    = 19,
   parameter int CFG_W   = 13,
   parameter int CLK_DIV = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    start,
   output logic [$clog2(N_IO)-1:0] cfg_addr,
   input  logic [CFG_W-1:0]        cfg1_word,
   input  logic [CFG_W-1:0]        cfg2_word,
   input  logic                    bb_en,
   input  logic                    bb_resetn,
   input  logic                    bb_load,
   input  logic                    bb_clock,
   input  logic                    bb_data1,
   input  logic                    bb_data2,
   output logic                    serial_resetn,
   output logic                    serial_load,
   output logic                    serial_clock,
   output logic                    serial_data1,
   output logic                    serial_data2,
   output logic                    busy,
   output logic                    done
);

   localparam int ADDR_W = $clog2(N_IO);
   localparam int BIT_W  = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(N_IO - 1);
   localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(CFG_W - 1);
   localparam logic [DIV_W-1:0]  DIV_TOP  = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      LATCH    = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [ADDR_W-1:0] addr;
   logic [CFG_W-1:0]  sh1;
   logic [CFG_W-1:0]  sh2;
   logic              div_last;
   logic              leaving;

   logic              eng_resetn;
   logic              eng_load;
   logic              eng_clock;
   logic              eng_data1;
   logic              eng_data2;
   logic              done_q;

   assign div_last = (div_cnt == DIV_TOP);
   assign leaving  = (state != IDLE) && (state_nx == IDLE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (start && !bb_en) state_nx = FETCH;
         FETCH:    state_nx = SHIFT_LO;
         SHIFT_LO: if (div_last) state_nx = SHIFT_HI;
         SHIFT_HI: begin
            if (div_last) begin
               if (bit_cnt != '0)   state_nx = SHIFT_LO;
               else if (addr != '0) state_nx = FETCH;
               else                 state_nx = LATCH;
            end
         end
         LATCH:    if (div_last) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
      // Bit-bang takeover aborts any transfer in flight.
      if (bb_en && (state != IDLE)) state_nx = IDLE;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         div_cnt    <= '0;
         bit_cnt    <= '0;
         addr       <= ADDR_TOP;
         sh1        <= '0;
         sh2        <= '0;
         eng_resetn <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         eng_resetn <= 1'b1;
         done_q     <= (state == DONE) && !bb_en;

         // Phase timer runs only while a timed state persists.
         if ((state_nx == state) &&
             ((state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH))) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end else begin
            div_cnt <= '0;
         end

         if (state == FETCH) begin
            sh1     <= cfg1_word;
            sh2     <= cfg2_word;
            bit_cnt <= BIT_TOP;
         end

         if ((state == SHIFT_HI) && (state_nx == SHIFT_LO)) begin
            bit_cnt <= bit_cnt - BIT_W'(1);
         end

         if ((state == SHIFT_HI) && (state_nx == FETCH)) begin
            addr <= addr - ADDR_W'(1);
         end

         // Clearing the shifters keeps the data pins at 0 through the first FETCH.
         if (leaving) begin
            addr    <= ADDR_TOP;
            bit_cnt <= '0;
            sh1     <= '0;
            sh2     <= '0;
         end
      end
   end

   // Data stays on the last shifted bit through FETCH/LATCH so it only moves in SHIFT_LO.
   always_comb begin
      eng_clock = (state == SHIFT_HI);
      eng_load  = (state == LATCH);
      eng_data1 = 1'b0;
      eng_data2 = 1'b0;
      if (state != IDLE) begin
         eng_data1 = sh1[bit_cnt];
         eng_data2 = sh2[bit_cnt];
      end
   end

   // ------------------------------------------------------------ pin mux
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         serial_resetn <= 1'b0;
         serial_load   <= 1'b0;
         serial_clock  <= 1'b0;
         serial_data1  <= 1'b0;
         serial_data2  <= 1'b0;
      end else if (bb_en) begin
         serial_resetn <= bb_resetn;
         serial_load   <= bb_load;
         serial_clock  <= bb_clock;
         serial_data1  <= bb_data1;
         serial_data2  <= bb_data2;
      end else begin
         serial_resetn <= eng_resetn;
         serial_load   <= eng_load;
         serial_clock  <= eng_clock;
         serial_data1  <= eng_data1;
         serial_data2  <= eng_data2;
      end
   end

   assign cfg_addr = addr;
   assign busy     = (state != IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: a small instance (2x4 bits, CLK_DIV=1) for bit order and timing,
// and a default instance driving a model shift chain for full-length transfers.
module tb_gpio_serial_loader;

   localparam int D_N = 19;
   localparam int D_C = 13;
   localparam int D_BITS = D_N * D_C;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // small instance
   logic       s_start = 1'b0;
   logic [0:0] s_cfg_addr;
   logic [3:0] s_cfg1;
   logic [3:0] s_cfg2;
   logic       s_serial_resetn, s_serial_load, s_serial_clock;
   logic       s_serial_data1, s_serial_data2, s_busy, s_done;

   // default instance
   logic       d_start = 1'b0;
   logic [4:0] d_cfg_addr;
   logic       bb_en = 1'b0, bb_resetn = 1'b1, bb_load = 1'b0;
   logic       bb_clock = 1'b0, bb_data1 = 1'b0, bb_data2 = 1'b0;
   logic       d_serial_resetn, d_serial_load, d_serial_clock;
   logic       d_serial_data1, d_serial_data2, d_busy, d_done;

   int vectors = 0;
   int miscompares = 0;
   int got;

   always #5 clk = ~clk;

   assign s_cfg1 = (s_cfg_addr == 1'b1) ? 4'hA : 4'h3;
   assign s_cfg2 = (s_cfg_addr == 1'b1) ? 4'h5 : 4'hC;

   gpio_serial_loader #(.N_IO(2), .CFG_W(4), .CLK_DIV(1)) u_small (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(s_start), .cfg_addr(s_cfg_addr),
      .cfg1_word(s_cfg1), .cfg2_word(s_cfg2),
      .bb_en(1'b0), .bb_resetn(1'b1), .bb_load(1'b0), .bb_clock(1'b0),
      .bb_data1(1'b0), .bb_data2(1'b0),
      .serial_resetn(s_serial_resetn), .serial_load(s_serial_load),
      .serial_clock(s_serial_clock), .serial_data1(s_serial_data1),
      .serial_data2(s_serial_data2), .busy(s_busy), .done(s_done)
   );

   gpio_serial_loader u_dflt (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(d_start), .cfg_addr(d_cfg_addr),
      .cfg1_word(13'h1809), .cfg2_word(13'h1809),
      .bb_en(bb_en), .bb_resetn(bb_resetn), .bb_load(bb_load), .bb_clock(bb_clock),
      .bb_data1(bb_data1), .bb_data2(bb_data2),
      .serial_resetn(d_serial_resetn), .serial_load(d_serial_load),
      .serial_clock(d_serial_clock), .serial_data1(d_serial_data1),
      .serial_data2(d_serial_data2), .busy(d_busy), .done(d_done)
   );

   // ------------------------------------------------------------ monitors
   logic       s_clk_q = 1'b0, s_d1_q = 1'b0, s_d2_q = 1'b0, s_load_q = 1'b0;
   logic [7:0] s_bits1 = '0, s_bits2 = '0;
   int         s_rises = 0, s_loads = 0, s_load_cyc = 0, s_dones = 0, s_viol = 0;

   always @(negedge clk) begin
      s_clk_q  <= s_serial_clock;
      s_d1_q   <= s_serial_data1;
      s_d2_q   <= s_serial_data2;
      s_load_q <= s_serial_load;
      if (s_serial_clock && !s_clk_q) begin
         s_rises <= s_rises + 1;
         s_bits1 <= {s_bits1[6:0], s_serial_data1};
         s_bits2 <= {s_bits2[6:0], s_serial_data2};
      end
      if (s_serial_clock && ((s_serial_data1 != s_d1_q) || (s_serial_data2 != s_d2_q)))
         s_viol <= s_viol + 1;
      if (s_serial_load && !s_load_q) s_loads <= s_loads + 1;
      if (s_serial_load) s_load_cyc <= s_load_cyc + 1;
      if (s_done) s_dones <= s_dones + 1;
   end

   logic              d_clk_q = 1'b0, d_d1_q = 1'b0, d_d2_q = 1'b0, d_load_q = 1'b0;
   logic [D_BITS-1:0] chain = '0, latched = '0;
   int                d_rises = 0, d_loads = 0, d_dones = 0, d_viol = 0;

   always @(negedge clk) begin
      d_clk_q  <= d_serial_clock;
      d_d1_q   <= d_serial_data1;
      d_d2_q   <= d_serial_data2;
      d_load_q <= d_serial_load;
      if (d_serial_clock && !d_clk_q) d_rises <= d_rises + 1;
      if (!d_serial_resetn) chain <= '0;
      else if (d_serial_clock && !d_clk_q) chain <= {chain[D_BITS-2:0], d_serial_data1};
      if (d_serial_load && !d_load_q) begin
         d_loads <= d_loads + 1;
         latched <= chain;
      end
      if (d_serial_clock && ((d_serial_data1 != d_d1_q) || (d_serial_data2 != d_d2_q)))
         d_viol <= d_viol + 1;
      if (d_done) d_dones <= d_dones + 1;
   end

   // ------------------------------------------------------------- helpers
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_chain(input string tag);
      for (int i = 0; i < D_N; i++)
         check($sformatf("%s_blk%0d", tag, i), 64'(latched[i*D_C +: D_C]), 64'h1809);
   endtask

   task automatic wait_s_done(input int budget, output int cycles);
      cycles = -1;
      for (int k = 1; k <= budget; k++) begin
         tick(1);
         if (s_done) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic wait_d_done(input int budget, input int poke, output int cycles);
      cycles = -1;
      for (int k = 1; k <= budget; k++) begin
         tick(1);
         d_start = (k == poke);
         if (d_done) begin
            cycles = k;
            break;
         end
      end
      d_start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ sequence
   int r0, l0, lc0, dn0, v0;

   initial begin
      // reset
      tick(1);
      check("rst_s_busy", s_busy, 0);
      check("rst_d_busy", d_busy, 0);
      check("rst_d_done", d_done, 0);
      check("rst_s_addr", s_cfg_addr, 1);
      check("rst_d_addr", d_cfg_addr, 18);
      check("rst_d_resetn", d_serial_resetn, 0);
      rst = 1'b0;
      tick(1);
      check("rel_resetn_lag", d_serial_resetn, 0);
      tick(1);
      check("rel_resetn_hi", d_serial_resetn, 1);
      check("rel_s_resetn_hi", s_serial_resetn, 1);
      tick(2);

      // small instance: bit order, load width, done latency
      r0 = s_rises; l0 = s_loads; lc0 = s_load_cyc; dn0 = s_dones; v0 = s_viol;
      s_start = 1'b1;
      tick(1);
      s_start = 1'b0;
      check("s_fetch_busy", s_busy, 1);
      check("s_fetch_addr", s_cfg_addr, 1);
      wait_s_done(40, got);
      check("s_done_latency", got, 20);
      check("s_busy_at_done", s_busy, 0);
      tick(3);
      check("s_rises", s_rises - r0, 8);
      check("s_data1_bits", s_bits1, 8'hA3);
      check("s_data2_bits", s_bits2, 8'h5C);
      check("s_load_pulses", s_loads - l0, 1);
      check("s_load_width", s_load_cyc - lc0, 1);
      check("s_done_pulses", s_dones - dn0, 1);
      check("s_data_stable", s_viol - v0, 0);
      check("s_addr_back", s_cfg_addr, 1);

      // small instance: reset during LATCH
      dn0 = s_dones;
      s_start = 1'b1;
      tick(1);
      s_start = 1'b0;
      tick(18);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("latch_rst_load", s_serial_load, 0);
      check("latch_rst_resetn0", s_serial_resetn, 0);
      check("latch_rst_busy", s_busy, 0);
      check("latch_rst_addr", s_cfg_addr, 1);
      tick(1);
      check("latch_rst_resetn1", s_serial_resetn, 0);
      tick(1);
      check("latch_rst_resetn2", s_serial_resetn, 1);
      tick(10);
      check("latch_rst_no_done", s_dones - dn0, 0);

      // default instance: full transfer, start while busy ignored
      r0 = d_rises; l0 = d_loads; dn0 = d_dones; v0 = d_viol;
      d_start = 1'b1;
      tick(1);
      d_start = 1'b0;
      check("d_fetch_busy", d_busy, 1);
      check("d_fetch_addr", d_cfg_addr, 18);
      wait_d_done(2100, 500, got);
      check("d_done_latency", got, 2000);
      tick(20);
      check("d_rises", d_rises - r0, D_BITS);
      check("d_load_pulses", d_loads - l0, 1);
      check("d_done_pulses", d_dones - dn0, 1);
      check("d_data_stable", d_viol - v0, 0);
      check("d_idle_busy", d_busy, 0);
      check("d_addr_back", d_cfg_addr, 18);
      check_chain("xfer1");

      // start while bit-bang owns the pins
      bb_en = 1'b1;
      tick(2);
      r0 = d_rises; dn0 = d_dones;
      d_start = 1'b1;
      tick(1);
      d_start = 1'b0;
      tick(30);
      check("bb_start_busy", d_busy, 0);
      check("bb_start_rises", d_rises - r0, 0);
      check("bb_start_done", d_dones - dn0, 0);

      // bit-bang mirroring, one cycle late
      bb_clock = 1'b1; bb_data1 = 1'b1; bb_resetn = 1'b0;
      check("bb_clock_pre", d_serial_clock, 0);
      tick(1);
      check("bb_clock_hi", d_serial_clock, 1);
      check("bb_data1_hi", d_serial_data1, 1);
      check("bb_resetn_lo", d_serial_resetn, 0);
      bb_clock = 1'b0; bb_load = 1'b1;
      tick(1);
      check("bb_clock_lo", d_serial_clock, 0);
      check("bb_load_hi", d_serial_load, 1);
      bb_load = 1'b0; bb_resetn = 1'b1; bb_data2 = 1'b1;
      tick(1);
      check("bb_resetn_hi", d_serial_resetn, 1);
      check("bb_data2_hi", d_serial_data2, 1);
      check("bb_load_lo", d_serial_load, 0);
      check("bb_latched_clear", latched, 0);
      bb_data1 = 1'b0; bb_data2 = 1'b0; bb_en = 1'b0;
      tick(3);

      // abort at bit 5 of the cfg_addr=7 word
      dn0 = d_dones;
      d_start = 1'b1;
      tick(1);
      d_start = 1'b0;
      tick(1214);
      check("abort_addr_before", d_cfg_addr, 7);
      check("abort_busy_before", d_busy, 1);
      bb_en = 1'b1; bb_resetn = 1'b0;
      tick(1);
      check("abort_busy", d_busy, 0);
      check("abort_addr", d_cfg_addr, 18);
      tick(1);
      check("abort_clock", d_serial_clock, 0);
      check("abort_load", d_serial_load, 0);
      tick(40);
      check("abort_no_done", d_dones - dn0, 0);
      bb_en = 1'b0;
      tick(1);
      check("abort_eng_resetn", d_serial_resetn, 1);
      check("abort_eng_clock", d_serial_clock, 0);
      bb_resetn = 1'b1;
      tick(2);

      // restart after abort: full transfer again
      r0 = d_rises; l0 = d_loads; dn0 = d_dones; v0 = d_viol;
      d_start = 1'b1;
      tick(1);
      d_start = 1'b0;
      check("re_fetch_addr", d_cfg_addr, 18);
      wait_d_done(2100, 0, got);
      check("re_done_latency", got, 2000);
      tick(5);
      check("re_rises", d_rises - r0, D_BITS);
      check("re_load_pulses", d_loads - l0, 1);
      check("re_done_pulses", d_dones - dn0, 1);
      check("re_data_stable", d_viol - v0, 0);
      check_chain("xfer2");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
